// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters the FIFO write port for bursts of
// up to BURST_LEN beats. Define FIFO_WR_ARB_BURST_EN for bursts; otherwise grants are single-beat.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                        clk_w,
    input  logic                        rst_w,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        full,
    output logic                        w_en,
    output logic [DATA_W-1:0]           w_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BURST_LEN) + 1;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int unsigned Beats = BURST_LEN;
`else
    localparam int unsigned Beats = 1;
`endif
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);
    localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q;
    logic [IdW-1:0]   owner_q;
    logic [IdW-1:0]   rr_ptr_q;
    logic [CntW-1:0]  beat_cnt_q;
    logic [IdW-1:0]   next_ptr;
    logic [DATA_W-1:0] owner_data;

    // First valid requester at or after ptr, searching cyclically.
    function automatic logic [IdW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IdW-1:0] ptr);
        logic [IdW-1:0] pick;
        logic [IdW-1:0] cand;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IdW'((int'(ptr) + k) % int'(NUM_REQ));
            if (valid[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign next_ptr = (owner_q == LastId) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        owner_q    <= rr_pick(req_valid, rr_ptr_q);
                        beat_cnt_q <= '0;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    // A full FIFO freezes the grant, even if the owner withdraws.
                    if (!full) begin
                        if (req_valid[owner_q]) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                            if (beat_cnt_q == LastBeat) begin
                                state_q  <= StIdle;
                                rr_ptr_q <= next_ptr;
                            end
                        end else begin
                            state_q  <= StIdle;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        req_ready  = '0;
        owner_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner_q == IdW'(i)) begin
                req_ready[i] = (state_q == StGrant) && !full;
                owner_data   = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_en     = |(req_valid & req_ready);
    assign w_data   = (state_q == StGrant) ? owner_data : '0;
    assign grant_id = owner_q;
    assign busy     = (state_q == StGrant);

endmodule
